// File: rtl/bpsk_frame_serializer.sv
// bpsk_frame_serializer
// Buffers whole packets in a small FIFO and frames each one as
// preamble -> payload -> idle gap. One bit is emitted per ser_next strobe
// from signal_modulator. ser_clear marks the end of every payload.
module bpsk_frame_serializer #(
  parameter int          PACKET_SIZE  = 192,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          PREAMBLE_LEN = 16,
  parameter logic [31:0] PREAMBLE     = 32'h0000_AAAA,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter int          GAP_BITS     = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [PACKET_SIZE-1:0]          pkt_data,
  input  logic                            pkt_valid,
  output logic                            pkt_ready,
  input  logic                            ser_next,
  output logic                            ser_signal,
  output logic                            ser_clear,
  output logic                            ser_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow
);

  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MAX_A   = (PREAMBLE_LEN > PACKET_SIZE) ? PREAMBLE_LEN : PACKET_SIZE;
  localparam int MAX_LEN = (GAP_BITS > MAX_A) ? GAP_BITS : MAX_A;
  localparam int BW      = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] PRE_LAST  = BW'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
  localparam logic [BW-1:0] PAY_LAST  = BW'(PACKET_SIZE - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [31:0]   PRE_TOP   = (PREAMBLE_LEN > 0) ? 32'(PREAMBLE_LEN - 1) : 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_PAY  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [PACKET_SIZE-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]          count_r;
  logic                   ovf_r;
  logic [PACKET_SIZE-1:0] sh_r, sh_nxt_s;
  logic [BW-1:0]          cnt_r, cnt_nxt_s;
  logic                   sig_r, sig_nxt_s;
  logic                   clr_r, clr_nxt_s;
  logic                   busy_r, busy_nxt_s;
  logic                   push_s, pop_s;
  logic [PACKET_SIZE-1:0] head_data_s;

  // Payload bit that goes out next, honouring the selected bit order.
  function automatic logic head_bit(input logic [PACKET_SIZE-1:0] v);
    if (MSB_FIRST) begin
      return v[PACKET_SIZE-1];
    end else begin
      return v[0];
    end
  endfunction

  // Drop the bit just presented so the next one sits at the head.
  function automatic logic [PACKET_SIZE-1:0] shift_out(input logic [PACKET_SIZE-1:0] v);
    if (MSB_FIRST) begin
      return v << 1;
    end else begin
      return v >> 1;
    end
  endfunction

  function automatic logic pre_bit(input logic [31:0] idx);
    return PREAMBLE[idx[4:0]];
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  // A full FIFO refuses pushes even while a pop is under way (no same-cycle refill).
  assign pkt_ready   = (count_r < DEPTH_C);
  assign push_s      = pkt_valid && pkt_ready;
  assign pop_s       = (state_r == ST_IDLE) && (count_r != CNT_ZERO);
  assign head_data_s = mem_r[rd_ptr_r];

  assign ser_signal  = sig_r;
  assign ser_clear   = clr_r;
  assign ser_busy    = busy_r;
  assign fifo_count  = count_r;
  assign overflow    = ovf_r;

  // FIFO storage; contents need no reset because count_r gates every read.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= pkt_data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      ovf_r <= ovf_r | (pkt_valid & ~pkt_ready);
    end
  end

  // Framer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: each framing phase ends on the strobe consuming its last bit.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_nxt_s = (PREAMBLE_LEN > 0) ? ST_PRE : ST_PAY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (ser_next && (cnt_r == PRE_LAST)) begin
          state_nxt_s = ST_PAY;
        end else begin
          state_nxt_s = ST_PRE;
        end
      end
      ST_PAY: begin
        if (ser_next && (cnt_r == PAY_LAST)) begin
          state_nxt_s = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
        end else begin
          state_nxt_s = ST_PAY;
        end
      end
      ST_GAP: begin
        if (ser_next && (cnt_r == GAP_LAST)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output and datapath next values; the bit counter restarts on every state entry.
  always_comb begin
    sh_nxt_s   = sh_r;
    cnt_nxt_s  = cnt_r;
    sig_nxt_s  = sig_r;
    clr_nxt_s  = 1'b0;
    busy_nxt_s = (state_nxt_s == ST_PRE) || (state_nxt_s == ST_PAY);
    case (state_r)
      ST_IDLE: begin
        sig_nxt_s = 1'b0;
        if (pop_s) begin
          cnt_nxt_s = BIT_ZERO;
          if (PREAMBLE_LEN > 0) begin
            sh_nxt_s  = head_data_s;
            sig_nxt_s = pre_bit(PRE_TOP);
          end else begin
            sh_nxt_s  = shift_out(head_data_s);
            sig_nxt_s = head_bit(head_data_s);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_PRE: begin
        if (ser_next) begin
          if (cnt_r == PRE_LAST) begin
            cnt_nxt_s = BIT_ZERO;
            sig_nxt_s = head_bit(sh_r);
            sh_nxt_s  = shift_out(sh_r);
          end else begin
            cnt_nxt_s = cnt_r + BIT_ONE;
            sig_nxt_s = pre_bit(PRE_TOP - 32'(cnt_r) - 32'd1);
          end
        end else begin
          sig_nxt_s = sig_r;
        end
      end
      ST_PAY: begin
        if (ser_next) begin
          if (cnt_r == PAY_LAST) begin
            cnt_nxt_s = BIT_ZERO;
            sig_nxt_s = 1'b0;
            clr_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + BIT_ONE;
            sig_nxt_s = head_bit(sh_r);
            sh_nxt_s  = shift_out(sh_r);
          end
        end else begin
          sig_nxt_s = sig_r;
        end
      end
      ST_GAP: begin
        sig_nxt_s = 1'b0;
        if (ser_next) begin
          if (cnt_r == GAP_LAST) begin
            cnt_nxt_s = BIT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + BIT_ONE;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        sig_nxt_s = 1'b0;
        cnt_nxt_s = BIT_ZERO;
      end
    endcase
  end

  // Registered serializer outputs, shift register and bit counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_r   <= {PACKET_SIZE{1'b0}};
      cnt_r  <= BIT_ZERO;
      sig_r  <= 1'b0;
      clr_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      sh_r   <= sh_nxt_s;
      cnt_r  <= cnt_nxt_s;
      sig_r  <= sig_nxt_s;
      clr_r  <= clr_nxt_s;
      busy_r <= busy_nxt_s;
    end
  end

endmodule

// File: doc/bpsk_frame_serializer.md
# bpsk_frame_serializer

Parametrised successor to the fixed-packet serializer that feeds `signal_modulator`. Accepts whole packets over a valid/ready handshake into a FIFO of configurable depth. Wraps each packet in a frame: programmable preamble, payload in selectable bit order, then an idle gap. Emits one bit per `ser_next` strobe from the modulator and pulses `ser_clear` at end of payload, so the receiver/UART chain can be driven by a stream of back-to-back frames rather than one hard-coded packet.

## Interface
Parameters:
- `PACKET_SIZE`, 192: payload bits per packet.
- `FIFO_DEPTH`, 4: packets buffered; integer ≥ 1.
- `PREAMBLE_LEN`, 16: preamble bits; range 0–32.
- `PREAMBLE`, 32'h0000_AAAA: preamble pattern; bit `PREAMBLE_LEN-1` is sent first.
- `MSB_FIRST`, 1: 1 sends payload bit `PACKET_SIZE-1` first; 0 sends bit 0 first.
- `GAP_BITS`, 8: idle zero bits after the payload; range 0–255.

Ports:
- `clock`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `pkt_data`  in  PACKET_SIZE  packet to enqueue.
- `pkt_valid`  in  1  `pkt_data` is valid.
- `pkt_ready`  out  1  high when `fifo_count < FIFO_DEPTH`; combinational from the registered count.
- `ser_next`  in  1  single-cycle strobe from the modulator requesting the next bit.
- `ser_signal`  out  1  current bit presented to the modulator.
- `ser_clear`  out  1  one-cycle pulse when the payload ends.
- `ser_busy`  out  1  high in PREAMBLE and PAYLOAD.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  number of packets queued, excluding the frame in flight.
- `overflow`  out  1  sticky flag; set when `pkt_valid` is high while `pkt_ready` is low; cleared only by reset.

## Operation
- **FIFO**
  - A push occurs when `pkt_valid && pkt_ready`.
  - A pop occurs only on the IDLE→PREAMBLE transition.
  - A push and a pop in the same cycle leave `fifo_count` unchanged.
  - When the FIFO is full, `pkt_ready` stays low even in a pop cycle: no same-cycle refill.
- **State machine:** IDLE, PREAMBLE, PAYLOAD, GAP.
  - **IDLE**
    - `ser_signal`=0.
    - If `fifo_count>0`: pop the head into the payload shift register, reset the bit counter, and go to PREAMBLE. If `PREAMBLE_LEN`=0, go directly to PAYLOAD.
    - `ser_next` is ignored in IDLE and in the transition cycle.
  - **PREAMBLE**
    - `ser_signal` presents preamble bits from `PREAMBLE[PREAMBLE_LEN-1]` down to bit 0.
    - Each `ser_next` advances one bit.
    - The strobe that consumes the last preamble bit presents the first payload bit and enters PAYLOAD.
  - **PAYLOAD**
    - Bits are presented in `MSB_FIRST` order, advancing on each `ser_next`.
    - The strobe consuming bit `PACKET_SIZE-1` of the sequence drives `ser_signal`=0 and pulses `ser_clear` for one cycle.
    - It then enters GAP, or IDLE if `GAP_BITS`=0.
  - **GAP**
    - `ser_signal`=0.
    - Counts `GAP_BITS` strobes, then enters IDLE.
- **Counter width:** the bit counter is sized for `max(PREAMBLE_LEN, PACKET_SIZE, GAP_BITS)` and is reset on every state entry.
- **Reset:** asynchronous. Aborts any frame in flight, empties the FIFO, and produces no `ser_clear`.

## Timing
- **Reset values:**
  - state IDLE.
  - `ser_signal`=0, `ser_clear`=0, `ser_busy`=0, `fifo_count`=0, `overflow`=0.
  - `pkt_ready`=1.
- **Output registers:** all outputs except `pkt_ready` are registered.
- **Bit update:** `ser_signal` changes on the clock edge after the cycle in which `ser_next` is sampled high.
- **Enqueue latency:** a push accepted in cycle N, with the block IDLE and FIFO empty, gives:
  - `fifo_count`=1 in N+1.
  - Pop and first preamble bit on `ser_signal` in N+2.
  - `ser_busy`=1 from N+2.
- **`ser_clear`:** asserted in the same cycle that `ser_signal` first shows the gap/idle 0. Deasserts the next cycle.
- **Frame length:** `PREAMBLE_LEN+PACKET_SIZE+GAP_BITS` strobes. With `ser_next` held high, one bit per cycle and exactly one IDLE cycle between frames.
- **`ser_next` duty:** held high is treated as one strobe per cycle; there is no edge detection.

## Test plan
1. **Reset:** assert `reset` asynchronously, mid-cycle -> all outputs take their reset values immediately; `pkt_ready`=1.
2. **Single frame:** push 192'hff5468697320697320612074657374206d65737361676521, defaults, `ser_next` every 4 cycles -> 16 bits 1010…10, then payload 1111_1111_0101_0100…0010_0001, `ser_clear` once after the 208th strobe, then 8 zeros, then IDLE.
3. **LSB-first:** `MSB_FIRST`=0, same packet -> payload begins 1,0,0,0,0,1,0,0 (bits of 0x21, LSB first) and ends with eight 1s from 0xff.
4. **Overflow:** `ser_next` held 0, push 6 packets back-to-back -> first is popped into the shift register, next 4 fill the FIFO, `pkt_ready`=0 with `fifo_count`=4, 6th refused, `overflow`=1 and stays 1.
5. **Back-to-back frames:** `ser_next` held 1 with 2 packets queued -> 216 cycles per frame, one IDLE cycle between frames, exactly 2 `ser_clear` pulses.
6. **Reset mid-payload:** assert `reset` at payload bit 100 with 2 queued -> `ser_signal`=0, `fifo_count`=0, no `ser_clear`; after release the block stays IDLE until a new push.
